// File: rtl/brisc_pkg.sv
// brisc_pkg: shared types and constants for the hazard scoreboard
package brisc_pkg;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_BITS = $clog2(NUM_REGS_DEF);
  localparam int MUL_LAT_DEF = 5;
  localparam int CNT_BITS = 3;
  typedef enum logic [1:0] {UNIT_ALU, UNIT_MUL, UNIT_MEM} unit_e;
  typedef struct packed {
    logic busy;
    logic ready;
    unit_e unit;
    logic [CNT_BITS-1:0] cnt;
  } sb_entry_t;
endpackage

// File: rtl/sb_entry.sv
// sb_entry: state of one register's pending write (alloc > retire > mem done > countdown)
module sb_entry
  import brisc_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  alloc_in,
  input  unit_e alloc_unit_in,
  input  logic  freeze_in,
  input  logic  done_in,
  input  logic  retire_in,
  output logic  busy_out,
  output logic  ready_out
);
  sb_entry_t entry_q, entry_d;
  always_comb begin
    entry_d = entry_q;
    if (alloc_in) begin
      entry_d.busy = 1'b1;
      entry_d.ready = (alloc_unit_in == UNIT_ALU) || (alloc_unit_in == UNIT_MUL && MUL_LAT == 1);
      entry_d.unit = alloc_unit_in;
      entry_d.cnt = alloc_unit_in == UNIT_MUL ? CNT_BITS'(MUL_LAT - 1) : '0;
    end else if (retire_in) begin
      entry_d.busy = 1'b0;
      entry_d.ready = 1'b0;
      entry_d.cnt = '0;
    end else if (entry_q.busy) begin
      if (done_in && entry_q.unit == UNIT_MEM) entry_d.ready = 1'b1;
      if (entry_q.unit == UNIT_MUL && entry_q.cnt != '0 && !freeze_in) begin
        entry_d.cnt = entry_q.cnt - 1'b1;
        entry_d.ready = entry_q.ready | (entry_q.cnt == CNT_BITS'(1));
      end
    end
  end
  always_ff @(posedge clk) entry_q <= reset ? '0 : entry_d;
  assign busy_out = entry_q.busy;
  assign ready_out = entry_q.ready;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes and stalls A on uncovered RAW/WAW hazards
module hazard_scoreboard
  import brisc_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid_in,
  input  logic                issue_writes_in,
  input  unit_e               issue_unit_in,
  input  logic [REG_BITS-1:0] issue_rd_in,
  input  logic [REG_BITS-1:0] rs1_in,
  input  logic [REG_BITS-1:0] rs2_in,
  input  logic                rs1_used_in,
  input  logic                rs2_used_in,
  input  logic                mem_done_in,
  input  logic [REG_BITS-1:0] mem_rd_in,
  input  logic                freeze_in,
  input  logic                flush_in,
  input  logic                retire_valid_in,
  input  logic [REG_BITS-1:0] retire_rd_in,
  output logic                stall_out,
  output logic [NUM_REGS-1:0] busy_vec_out,
  output logic                err_out
);
  logic [NUM_REGS-1:0] busy_w, ready_w, pend_w;
  logic alloc_ok, raw1, raw2, waw, err_d, err_q;
  assign busy_w[0] = 1'b0;
  assign ready_w[0] = 1'b0;
  assign alloc_ok = issue_valid_in & issue_writes_in & !stall_out & !flush_in;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_ent
    sb_entry #(.MUL_LAT(MUL_LAT)) u_ent (
      .clk          (clk),
      .reset        (reset),
      .alloc_in     (alloc_ok && issue_rd_in == REG_BITS'(g)),
      .alloc_unit_in(issue_unit_in),
      .freeze_in    (freeze_in),
      .done_in      (mem_done_in && mem_rd_in == REG_BITS'(g)),
      .retire_in    (retire_valid_in && retire_rd_in == REG_BITS'(g)),
      .busy_out     (busy_w[g]),
      .ready_out    (ready_w[g])
    );
  end
  assign pend_w = busy_w & ~ready_w;
  always_comb begin
    raw1 = rs1_used_in && pend_w[rs1_in];
    raw2 = rs2_used_in && pend_w[rs2_in];
    waw = issue_writes_in && pend_w[issue_rd_in];
    stall_out = issue_valid_in && !flush_in && !reset && (raw1 || raw2 || waw);
    err_d = err_q || (retire_valid_in && retire_rd_in != '0 && !busy_w[retire_rd_in]);
  end
  always_ff @(posedge clk) err_q <= reset ? 1'b0 : err_d;
  assign busy_vec_out = busy_w;
  assign err_out = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of hazard_scoreboard allocation, countdown, stall and error behaviour
module tb_hazard_scoreboard;
  import brisc_pkg::*;
  logic clk = 1'b0;
  logic reset, issue_valid, issue_writes, rs1_used, rs2_used, mem_done, freeze, flush, retire_valid;
  unit_e issue_unit;
  logic [4:0] issue_rd, rs1, rs2, mem_rd, retire_rd;
  logic stall, err;
  logic [31:0] busy_vec;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid_in(issue_valid), .issue_writes_in(issue_writes),
    .issue_unit_in(issue_unit), .issue_rd_in(issue_rd), .rs1_in(rs1), .rs2_in(rs2),
    .rs1_used_in(rs1_used), .rs2_used_in(rs2_used), .mem_done_in(mem_done), .mem_rd_in(mem_rd),
    .freeze_in(freeze), .flush_in(flush), .retire_valid_in(retire_valid), .retire_rd_in(retire_rd),
    .stall_out(stall), .busy_vec_out(busy_vec), .err_out(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; issue_valid = 0; issue_writes = 0; issue_unit = UNIT_ALU; issue_rd = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; mem_done = 0; mem_rd = 0;
    freeze = 0; flush = 0; retire_valid = 0; retire_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input unit_e u, input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_writes = 1; issue_unit = u; issue_rd = rd;
  endtask

  task automatic retire(input logic [4:0] rd);
    idle();
    retire_valid = 1; retire_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_err", 32'(err), 0);
    // ALU result is forwardable the cycle after issue
    issue(UNIT_ALU, 5); #1;
    chk("alu_issue_stall", 32'(stall), 0);
    tick();
    idle(); issue_valid = 1; rs1 = 5; rs1_used = 1; #1;
    chk("alu_raw_stall", 32'(stall), 0);
    chk("alu_busy5", 32'(busy_vec[5]), 1);
    tick();
    retire(5); #1;
    chk("alu_busy_before_retire", 32'(busy_vec[5]), 1);
    tick();
    idle(); #1;
    chk("alu_busy_after_retire", busy_vec, 0);
    chk("alu_err", 32'(err), 0);
    // MUL: four stall cycles then free
    issue(UNIT_MUL, 7); tick();
    idle(); issue_valid = 1; rs2 = 7; rs2_used = 1;
    for (int i = 1; i <= 4; i++) begin
      #1; chk($sformatf("mul_stall_c%0d", i), 32'(stall), 1); tick();
    end
    #1; chk("mul_stall_c5", 32'(stall), 0);
    retire(7); tick();
    // MUL with two frozen cycles stretches the stall to six cycles
    issue(UNIT_MUL, 7); tick();
    idle(); issue_valid = 1; rs2 = 7; rs2_used = 1;
    for (int i = 1; i <= 6; i++) begin
      freeze = (i == 2 || i == 3);
      #1; chk($sformatf("mulfrz_stall_c%0d", i), 32'(stall), 1); tick();
    end
    freeze = 0;
    #1; chk("mulfrz_stall_c7", 32'(stall), 0);
    retire(7); tick();
    // MEM waits for mem_done
    issue(UNIT_MEM, 3); tick();
    idle(); issue_valid = 1; rs1 = 3; rs1_used = 1;
    #1; chk("mem_stall_a", 32'(stall), 1); tick();
    #1; chk("mem_stall_b", 32'(stall), 1);
    mem_done = 1; mem_rd = 3;
    #1; chk("mem_stall_done_cycle", 32'(stall), 1); tick();
    mem_done = 0;
    #1; chk("mem_stall_released", 32'(stall), 0);
    retire(3); tick();
    // mem_done and retire together: retire wins
    issue(UNIT_MEM, 3); tick();
    retire(3); mem_done = 1; mem_rd = 3; tick();
    idle(); #1;
    chk("memdone_retire_busy", 32'(busy_vec[3]), 0);
    // x0 is never tracked
    issue(UNIT_MUL, 0); tick();
    idle(); #1;
    chk("x0_busy", busy_vec, 0);
    retire(0); tick();
    idle(); issue_valid = 1; rs1 = 0; rs1_used = 1; rs2 = 0; rs2_used = 1; #1;
    chk("x0_stall", 32'(stall), 0);
    chk("x0_err", 32'(err), 0);
    // WAW on pending MUL
    issue(UNIT_MUL, 9); tick();
    issue(UNIT_ALU, 9); #1;
    chk("waw_stall", 32'(stall), 1);
    tick(); tick(); tick(); tick();
    issue(UNIT_ALU, 9); retire_valid = 1; retire_rd = 9; #1;
    chk("waw_clear_stall", 32'(stall), 0);
    tick();
    idle(); #1;
    chk("alloc_retire_busy", 32'(busy_vec[9]), 1);
    chk("alloc_retire_err", 32'(err), 0);
    issue(UNIT_MUL, 9); retire_valid = 1; retire_rd = 9; tick();
    idle(); issue_valid = 1; rs1 = 9; rs1_used = 1; #1;
    chk("new_writer_busy", 32'(busy_vec[9]), 1);
    chk("new_writer_stall", 32'(stall), 1);
    // spurious retire sets sticky error
    retire(12); tick();
    idle(); #1;
    chk("err_set", 32'(err), 1);
    tick(); #1;
    chk("err_sticky", 32'(err), 1);
    // flush suppresses allocation and stall
    issue(UNIT_ALU, 4); flush = 1; rs1 = 9; rs1_used = 1; #1;
    chk("flush_stall", 32'(stall), 0);
    tick();
    idle(); #1;
    chk("flush_busy4", 32'(busy_vec[4]), 0);
    // reset mid-MUL
    issue(UNIT_MUL, 7); tick();
    idle(); issue_valid = 1; rs2 = 7; rs2_used = 1; reset = 1; #1;
    chk("reset_stall_forced", 32'(stall), 0);
    tick();
    reset = 0; #1;
    chk("post_reset_stall", 32'(stall), 0);
    chk("post_reset_busy", busy_vec, 0);
    chk("post_reset_err", 32'(err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
